// File: rtl/vpipe_ctrl_shift_pkg.sv
// Shared vector-pipeline constants and the control entry layout.
package vpipe_ctrl_shift_pkg;

    localparam int unsigned VEC_PIPE_DEPTH = 9;
    localparam int unsigned REG_TAG_W      = 5;
    localparam int unsigned CTRL_W         = 64;

    // One control-pipe entry as carried between execute and writeback.
    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [REG_TAG_W-1:0] tag;
        logic [CTRL_W-1:0]    ctrl;
    } vpipe_entry_t;

endpackage : vpipe_ctrl_shift_pkg

// File: rtl/vpipe_ctrl_shift_pipe_stage_reg.sv
// Single control-pipe entry register: clears on flush, holds on stall.
module pipe_stage_reg
    import vpipe_ctrl_shift_pkg::*;
#(
    parameter int unsigned WIDTH = CTRL_W,
    parameter int unsigned TAGW  = REG_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             src_valid,
    input  logic             src_wr_en,
    input  logic [TAGW-1:0]  src_tag,
    input  logic [WIDTH-1:0] src_ctrl,
    output logic             valid,
    output logic             wr_en,
    output logic [TAGW-1:0]  tag,
    output logic [WIDTH-1:0] ctrl
);

    // Entry register; flush wins over stall so no stale write survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            wr_en <= 1'b0;
            tag   <= '0;
            ctrl  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            wr_en <= 1'b0;
            tag   <= '0;
            ctrl  <= '0;
        end else if (!stall) begin
            valid <= src_valid;
            wr_en <= src_wr_en;
            tag   <= src_tag;
            ctrl  <= src_ctrl;
        end
    end

endmodule : pipe_stage_reg

// File: rtl/vpipe_ctrl_shift.sv
// Control-bus delay line from vector execute to writeback with
// stall/flush, occupancy tracking and destination-tag hazard lookup.
module vpipe_ctrl_shift
    import vpipe_ctrl_shift_pkg::*;
#(
    parameter int unsigned DEPTH = VEC_PIPE_DEPTH,
    parameter int unsigned WIDTH = CTRL_W,
    parameter int unsigned TAGW  = REG_TAG_W,
    parameter int unsigned NQ    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    in_ctrl,
    input  logic [TAGW-1:0]                     in_tag,
    input  logic                                in_wr_en,
    input  logic                                stall,
    input  logic                                flush,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    out_ctrl,
    output logic [TAGW-1:0]                     out_tag,
    output logic                                out_wr_en,
    input  logic [NQ*TAGW-1:0]                  q_tag,
    output logic [NQ-1:0]                       q_hit,
    output logic [NQ*$clog2(DEPTH+1)-1:0]       q_dist,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy,
    output logic                                empty
);

    localparam int unsigned OCCW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] wr_en_vec;
    logic [TAGW-1:0]  tag_arr  [DEPTH];
    logic [WIDTH-1:0] ctrl_arr [DEPTH];

    logic             src0_wr_en;
    logic [TAGW-1:0]  src0_tag;
    logic [WIDTH-1:0] src0_ctrl;

    logic             acc;
    logic             leave;
    logic [OCCW-1:0]  occ_next;

    // Bubbles enter stage 0 as all-zero entries.
    always_comb begin
        src0_wr_en = in_valid & in_wr_en;
        src0_tag   = in_valid ? in_tag  : '0;
        src0_ctrl  = in_valid ? in_ctrl : '0;
    end

    genvar k;
    generate
        for (k = 0; k < int'(DEPTH); k++) begin : g_stage
            if (k == 0) begin : g_head
                pipe_stage_reg #(.WIDTH(WIDTH), .TAGW(TAGW)) u_stage (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .stall     (stall),
                    .flush     (flush),
                    .src_valid (in_valid),
                    .src_wr_en (src0_wr_en),
                    .src_tag   (src0_tag),
                    .src_ctrl  (src0_ctrl),
                    .valid     (valid_vec[k]),
                    .wr_en     (wr_en_vec[k]),
                    .tag       (tag_arr[k]),
                    .ctrl      (ctrl_arr[k])
                );
            end else begin : g_body
                pipe_stage_reg #(.WIDTH(WIDTH), .TAGW(TAGW)) u_stage (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .stall     (stall),
                    .flush     (flush),
                    .src_valid (valid_vec[k-1]),
                    .src_wr_en (wr_en_vec[k-1]),
                    .src_tag   (tag_arr[k-1]),
                    .src_ctrl  (ctrl_arr[k-1]),
                    .valid     (valid_vec[k]),
                    .wr_en     (wr_en_vec[k]),
                    .tag       (tag_arr[k]),
                    .ctrl      (ctrl_arr[k])
                );
            end
        end
    endgenerate

    // Writeback side sees the last stage directly.
    always_comb begin
        out_valid = valid_vec[DEPTH-1];
        out_wr_en = wr_en_vec[DEPTH-1];
        out_tag   = tag_arr[DEPTH-1];
        out_ctrl  = ctrl_arr[DEPTH-1];
    end

    // Incremental occupancy: one in, one out per unstalled shift.
    always_comb begin
        acc   = in_valid & ~stall;
        leave = valid_vec[DEPTH-1] & ~stall;
        if (flush) begin
            occ_next = '0;
        end else begin
            occ_next = OCCW'(occupancy + OCCW'(acc) - OCCW'(leave));
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    // Empty flag straight from the count.
    always_comb begin
        empty = (occupancy == '0);
    end

    // Hazard lookup; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        q_hit  = '0;
        q_dist = '0;
        for (int j = 0; j < int'(NQ); j++) begin
            for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
                if (valid_vec[s] && wr_en_vec[s] &&
                    (tag_arr[s] == q_tag[j*TAGW +: TAGW])) begin
                    q_hit[j]               = 1'b1;
                    q_dist[j*OCCW +: OCCW] = OCCW'(int'(DEPTH) - 1 - s);
                end
            end
        end
    end

    // The running count must always equal the number of live stages.
    occ_matches_valid: assert property (
        @(posedge clk) disable iff (!rst_n)
        occupancy == OCCW'($countones(valid_vec))
    );

endmodule : vpipe_ctrl_shift

// File: tb/tb_vpipe_ctrl_shift.sv
// Directed bench for vpipe_ctrl_shift at DEPTH=9.
module tb_vpipe_ctrl_shift;

    localparam int unsigned DEPTH = 9;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned TAGW  = 5;
    localparam int unsigned NQ    = 2;
    localparam int unsigned OCCW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     in_ctrl = '0;
    logic [TAGW-1:0]      in_tag = '0;
    logic                 in_wr_en = 1'b0;
    logic                 stall = 1'b0;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_ctrl;
    logic [TAGW-1:0]      out_tag;
    logic                 out_wr_en;
    logic [NQ*TAGW-1:0]   q_tag = '0;
    logic [NQ-1:0]        q_hit;
    logic [NQ*OCCW-1:0]   q_dist;
    logic [OCCW-1:0]      occupancy;
    logic                 empty;

    int checks   = 0;
    int failures = 0;

    vpipe_ctrl_shift #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAGW(TAGW), .NQ(NQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_tag    (in_tag),
        .in_wr_en  (in_wr_en),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .out_tag   (out_tag),
        .out_wr_en (out_wr_en),
        .q_tag     (q_tag),
        .q_hit     (q_hit),
        .q_dist    (q_dist),
        .occupancy (occupancy),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_tag   = '0;
        in_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ctrl !== 64'h0) begin failures++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
        checks++; if (out_tag !== 5'd0) begin failures++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
        checks++; if (out_wr_en !== 1'b0) begin failures++; $display("FAIL reset_out_wr_en got=%0b exp=0", out_wr_en); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (q_hit !== 2'b00) begin failures++; $display("FAIL reset_q_hit got=%0b exp=0", q_hit); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_ctrl = 64'hA5; in_tag = 5'd3; in_wr_en = 1'b1;
        step();
        clear_inputs();
        for (int c = 1; c <= 10; c++) begin
            checks++; if (out_valid !== (c == 9)) begin failures++; $display("FAIL single_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (c == 9)); end
            checks++; if (occupancy !== ((c <= 9) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL single_occ c=%0d got=%0d exp=%0d", c, occupancy, (c <= 9)); end
            checks++; if (empty !== (c > 9)) begin failures++; $display("FAIL single_empty c=%0d got=%0b exp=%0b", c, empty, (c > 9)); end
            if (c == 9) begin
                checks++; if (out_ctrl !== 64'hA5) begin failures++; $display("FAIL single_ctrl got=%0h exp=a5", out_ctrl); end
                checks++; if (out_tag !== 5'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", out_tag); end
                checks++; if (out_wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%0b exp=1", out_wr_en); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_ctrl = 64'hA5; in_tag = 5'd3; in_wr_en = 1'b1;
        step();
        clear_inputs();
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) begin
                stall = 1'b1;
                in_valid = 1'b1; in_ctrl = 64'hDEAD; in_tag = 5'd9; in_wr_en = 1'b1;
            end
            if (c == 7) begin
                stall = 1'b0;
                clear_inputs();
            end
            checks++; if (out_valid !== (c == 12)) begin failures++; $display("FAIL stall_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (c == 12)); end
            checks++; if (occupancy !== ((c <= 12) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL stall_occ c=%0d got=%0d exp=%0d", c, occupancy, (c <= 12)); end
            if (c >= 4 && c <= 7) begin
                checks++; if (out_ctrl !== 64'h0) begin failures++; $display("FAIL stall_out_ctrl c=%0d got=%0h exp=0", c, out_ctrl); end
            end
            if (c == 12) begin
                checks++; if (out_ctrl !== 64'hA5) begin failures++; $display("FAIL stall_ctrl got=%0h exp=a5", out_ctrl); end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int acc_n;
        int left_n;
        for (int c = 0; c < 30; c++) begin
            acc_n  = (c < 20) ? c : 20;
            left_n = (c <= 9) ? 0 : (((c - 9) > 20) ? 20 : (c - 9));
            checks++; if (out_valid !== (c >= 9 && c <= 28)) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%0b exp=%0b", c, out_valid, (c >= 9 && c <= 28)); end
            checks++; if (occupancy !== 4'(acc_n - left_n)) begin failures++; $display("FAIL b2b_occ c=%0d got=%0d exp=%0d", c, occupancy, acc_n - left_n); end
            if (c >= 9 && c <= 28) begin
                checks++; if (out_ctrl !== 64'(c - 9)) begin failures++; $display("FAIL b2b_ctrl c=%0d got=%0d exp=%0d", c, out_ctrl, c - 9); end
            end
            in_valid = (c < 20);
            in_ctrl  = (c < 20) ? 64'(c) : 64'h0;
            in_tag   = (c < 20) ? 5'(c) : 5'd0;
            in_wr_en = (c < 20);
            step();
        end
        clear_inputs();
    endtask

    task automatic test_hazard();
        for (int c = 0; c <= 6; c++) begin
            clear_inputs();
            if (c == 0) begin in_valid = 1'b1; in_tag = 5'd7; in_wr_en = 1'b1; in_ctrl = 64'h1; end
            if (c == 4) begin in_valid = 1'b1; in_tag = 5'd7; in_wr_en = 1'b1; in_ctrl = 64'h2; end
            if (c == 5) begin in_valid = 1'b1; in_tag = 5'd7; in_wr_en = 1'b0; in_ctrl = 64'h3; end
            step();
        end
        // cycle 7: A in stage 6, B in stage 2, C (no write) in stage 1
        q_tag = {5'd4, 5'd7};
        in_valid = 1'b1; in_tag = 5'd4; in_wr_en = 1'b1; in_ctrl = 64'h44;
        #1;
        checks++; if (q_hit !== 2'b01) begin failures++; $display("FAIL hazard_hit got=%0b exp=01", q_hit); end
        checks++; if (q_dist[3:0] !== 4'd6) begin failures++; $display("FAIL hazard_dist0 got=%0d exp=6", q_dist[3:0]); end
        checks++; if (q_dist[7:4] !== 4'd0) begin failures++; $display("FAIL hazard_dist1 got=%0d exp=0", q_dist[7:4]); end
        q_tag = {5'd7, 5'd7};
        #1;
        checks++; if (q_hit !== 2'b11) begin failures++; $display("FAIL hazard_hit_both got=%0b exp=11", q_hit); end
        checks++; if (q_dist !== {4'd6, 4'd6}) begin failures++; $display("FAIL hazard_dist_both got=%0h exp=66", q_dist); end
        step();
        clear_inputs();
        // cycle 8: B in stage 3, tag-4 op in stage 0
        q_tag = {5'd4, 5'd7};
        #1;
        checks++; if (q_hit !== 2'b11) begin failures++; $display("FAIL hazard_hit_next got=%0b exp=11", q_hit); end
        checks++; if (q_dist[3:0] !== 4'd5) begin failures++; $display("FAIL hazard_dist0_next got=%0d exp=5", q_dist[3:0]); end
        checks++; if (q_dist[7:4] !== 4'd8) begin failures++; $display("FAIL hazard_dist1_stage0 got=%0d exp=8", q_dist[7:4]); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=0", occupancy); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_tag = 5'(10 + c); in_wr_en = 1'b1; in_ctrl = 64'(200 + c);
            step();
        end
        checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL flush_occ5 got=%0d exp=5", occupancy); end
        flush = 1'b1; stall = 1'b1;
        in_valid = 1'b1; in_tag = 5'd12; in_wr_en = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        clear_inputs();
        q_tag = {5'd12, 5'd10};
        #1;
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0b exp=1", empty); end
        checks++; if (q_hit !== 2'b00) begin failures++; $display("FAIL flush_q_hit got=%0b exp=00", q_hit); end
        for (int c = 0; c < 9; c++) begin
            checks++; if (out_valid !== 1'b0 || out_wr_en !== 1'b0) begin failures++; $display("FAIL flush_out c=%0d got=%0b%0b exp=00", c, out_valid, out_wr_en); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_ctrl = 64'(100 + c); in_tag = 5'(c); in_wr_en = 1'b1;
            step();
        end
        checks++; if (out_valid !== 1'b1 || out_ctrl !== 64'd101) begin failures++; $display("FAIL rstmid_pre got=%0b/%0d exp=1/101", out_valid, out_ctrl); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ctrl !== 64'h0) begin failures++; $display("FAIL rstmid_out_ctrl got=%0h exp=0", out_ctrl); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%0b exp=1", empty); end
        clear_inputs();
        #2;
        rst_n = 1'b1;
        in_valid = 1'b1; in_ctrl = 64'd77; in_tag = 5'd21; in_wr_en = 1'b1;
        step();
        clear_inputs();
        for (int c = 1; c <= 10; c++) begin
            checks++; if (out_valid !== (c == 9)) begin failures++; $display("FAIL rstmid_lat c=%0d got=%0b exp=%0b", c, out_valid, (c == 9)); end
            checks++; if (occupancy !== ((c <= 9) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL rstmid_occ_after c=%0d got=%0d exp=%0d", c, occupancy, (c <= 9)); end
            if (c == 9) begin
                checks++; if (out_ctrl !== 64'd77 || out_tag !== 5'd21) begin failures++; $display("FAIL rstmid_data got=%0d/%0d exp=77/21", out_ctrl, out_tag); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_hazard();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vpipe_ctrl_shift
